xcorr_search: RTL and testbench
===============================

# xcorr_search

Parametrised sliding-window correlation search engine. Reads a signed template of `TMPL_LEN` samples and a signed signal of `SIG_LEN` samples from a single-port synchronous SRAM read port. It computes the dot product of the template against every window position of the signal and reports the best score and its position. It sits between the sample SRAM and the result display/UART logic. Compared with the fixed 64/1024 engine, it adds a start/done handshake, configurable sizes and base addresses, and a max-absolute search mode.

## Interface

- `DATA_W`, 8: sample width, signed two's complement.
- `TMPL_LEN`, 64: template length; must be ≥ 1.
- `SIG_LEN`, 1024: signal length; must be ≥ `TMPL_LEN`.
- `ADDR_W`, 11: SRAM address width.
- `TMPL_BASE`, 0: SRAM address of template sample 0.
- `SIG_BASE`, 64: SRAM address of signal sample 0.
- Derived: `N_POS = SIG_LEN-TMPL_LEN+1`; `ACC_W = 2*DATA_W+clog2(TMPL_LEN)`; `IDX_W = clog2(N_POS)` (minimum 1).

Ports:

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low; clock `clk`.
- `start`  in  1  request a search; sampled only in IDLE.
- `mode`  in  1  0 = maximise signed score; 1 = maximise |score|. Latched when `start` is accepted.
- `mem_en`  out  1  SRAM read enable.
- `mem_addr`  out  `ADDR_W`  SRAM read address.
- `mem_rdata`  in  `DATA_W`  SRAM read data, valid the cycle after `mem_en`.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE, inclusive.
- `done`  out  1  one-cycle pulse when the result is final.
- `result_valid`  out  1  set with `done`; cleared by reset or the next accepted `start`.
- `best_val`  out  `ACC_W`  signed score of the winning window. In mode 1 it is the signed sum, not its magnitude.
- `best_idx`  out  `IDX_W`  signal index of the first sample of the winning window.

## Operation

- States: IDLE, LOAD_T, LOAD_S, MAC, CMP, FETCH, WRITE, DONE.
- **IDLE**
  - `start` = 1 → LOAD_T.
  - Latch `mode`, clear `result_valid`, and set `pos` = 0.
- **LOAD_T** (`TMPL_LEN+1` cycles)
  - Cycle k < `TMPL_LEN`: `mem_en` = 1, `mem_addr` = `TMPL_BASE+k`.
  - Cycle k ≥ 1: capture `mem_rdata` into `tmpl[k-1]`.
  - Then → LOAD_S.
- **LOAD_S**: same pattern from `SIG_BASE` into window buffer `win[0..TMPL_LEN-1]`. Set `head` = 0, then → MAC.
- **MAC** (`TMPL_LEN` cycles)
  - Cycle j: `acc += tmpl[j] * win[(head+j) mod TMPL_LEN]`.
  - `acc` is cleared at MAC entry.
  - The product is a full `2*DATA_W`-bit signed value, sign-extended to `ACC_W`. No saturation is needed because it cannot overflow.
- **CMP** (1 cycle)
  - Take the candidate if `pos` = 0, or if the metric is strictly greater than the stored best.
  - Metric: `acc` in mode 0; `|acc|` in mode 1, computed at `ACC_W+1` bits so that the most negative value is handled.
  - Ties keep the lower `best_idx`.
  - If `pos` = `N_POS-1` → DONE; else → FETCH.
- **FETCH** (1 cycle): `mem_en` = 1, `mem_addr` = `SIG_BASE+pos+TMPL_LEN`.
- **WRITE** (1 cycle)
  - `win[head]` ← `mem_rdata`.
  - `head` ← `(head+1) mod TMPL_LEN`, `pos` ← `pos+1`.
  - Then → MAC. The circular buffer replaces a physical shift.
- **DONE** (1 cycle): `done` = 1, `result_valid` ← 1, then → IDLE.
- `mem_en` = 0 in every state and cycle not listed above; `mem_addr` is don't-care when `mem_en` = 0.
- `start` is ignored outside IDLE and has no queueing.

## Timing

- Reset (`rst_n` = 0 at an edge):
  - State → IDLE.
  - `busy`, `done`, `result_valid`, `mem_en`, `best_val`, `best_idx` all → 0.
  - Reset mid-operation aborts the search with no partial result exposed.
- `start` is accepted at edge E; LOAD_T is the first cycle after E.
- Cycle count from LOAD_T entry to the DONE cycle: `2*(TMPL_LEN+1) + N_POS*(TMPL_LEN+1) + 2*(N_POS-1)`. `done` is high in the cycle after that count.
  - Default configuration: 130 + 62,465 + 1,920 = 64,515.
  - Configuration `TMPL_LEN`=4, `SIG_LEN`=8: 10 + 25 + 8 = 43, so `done` is high in the 44th cycle after E.
- `best_val` and `best_idx` update only in CMP and are stable while `result_valid` = 1.
- A new `start` may be accepted in the IDLE cycle immediately after DONE.
- With `SIG_LEN` = `TMPL_LEN`: `N_POS` = 1, there is no FETCH/WRITE, and `best_idx` = 0.

## Test plan

All scenarios use `DATA_W`=8, `TMPL_LEN`=4, `SIG_LEN`=8 unless noted.

1. Template [1,2,3,4], signal [0,0,1,2,3,4,0,0], mode 0 → `best_val` = 30, `best_idx` = 2, `done` pulses exactly 44 cycles after the `start` edge, and the `mem_addr` sequence matches the spec.
2. Template [1,1,1,1], signal [-128,-128,-128,-128,1,1,1,1]:
   - mode 0 → `best_val` = 4, `best_idx` = 4.
   - mode 1 → `best_val` = -512, `best_idx` = 0.
3. Tie: template [1,0,0,0], signal [5,0,0,0,5,0,0,0], mode 0 → `best_val` = 5, `best_idx` = 0.
4. Default parameters, all samples -128 → `best_val` = 1,048,576 with no overflow, `best_idx` = 0, and `done` at cycle 64,516 after `start`.
5. Handshake and reset:
   - Pulse `start` during MAC → ignored; result unchanged.
   - Assert `rst_n` = 0 for 1 cycle during MAC of position 2 → all outputs 0 next cycle.
   - Restart → result identical to scenario 1.
6. `SIG_LEN` = `TMPL_LEN` = 4, template [2,-3,0,1], signal [1,1,1,1] → `best_val` = 0, `best_idx` = 0, `done` after 10+5+1 = 16 cycles, and no FETCH access.

Source files
------------

// File: rtl/xcorr_search.sv
// Sliding-window correlation search: loads a template and signal window from SRAM,
// MACs every window position and keeps the best (signed or max-magnitude) score.
module xcorr_search #(
    parameter int DATA_W    = 8,
    parameter int TMPL_LEN  = 64,
    parameter int SIG_LEN   = 1024,
    parameter int ADDR_W    = 11,
    parameter int TMPL_BASE = 0,
    parameter int SIG_BASE  = 64,
    localparam int N_POS    = SIG_LEN - TMPL_LEN + 1,
    localparam int ACC_W    = 2 * DATA_W + $clog2(TMPL_LEN),
    localparam int IDX_W    = (N_POS > 1) ? $clog2(N_POS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    output logic                    mem_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    result_valid,
    output logic signed [ACC_W-1:0] best_val,
    output logic [IDX_W-1:0]        best_idx
);

    localparam int CNT_W  = $clog2(TMPL_LEN + 1);
    localparam int HEAD_W = (TMPL_LEN > 1) ? $clog2(TMPL_LEN) : 1;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [CNT_W-1:0]  CNT_LOAD_LAST = CNT_W'(TMPL_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAC_LAST  = CNT_W'(TMPL_LEN - 1);
    localparam logic [HEAD_W-1:0] HEAD_LAST     = HEAD_W'(TMPL_LEN - 1);
    localparam logic [HEAD_W:0]   SUM_WRAP      = (HEAD_W + 1)'(TMPL_LEN);
    localparam logic [IDX_W-1:0]  POS_LAST      = IDX_W'(N_POS - 1);
    localparam logic [ADDR_W-1:0] TMPL_BASE_A   = ADDR_W'(TMPL_BASE);
    localparam logic [ADDR_W-1:0] SIG_BASE_A    = ADDR_W'(SIG_BASE);
    localparam logic [ADDR_W-1:0] TMPL_LEN_A    = ADDR_W'(TMPL_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_T, S_LOAD_S, S_MAC, S_CMP, S_FETCH, S_WRITE, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [HEAD_W-1:0]       head_q, head_d;
    logic [IDX_W-1:0]        pos_q, pos_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    mode_q, mode_d;
    logic signed [ACC_W-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic                    valid_q, valid_d;

    logic signed [DATA_W-1:0] tmpl_q [TMPL_LEN];
    logic signed [DATA_W-1:0] win_q  [TMPL_LEN];

    logic                     tmpl_we, win_we;
    logic [HEAD_W-1:0]        buf_idx;
    logic [HEAD_W-1:0]        mac_j;
    logic [HEAD_W:0]          win_sum;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]    cand_m, best_m;
    logic                     take;

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        pos_d      = pos_q;
        acc_d      = acc_q;
        mode_d     = mode_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        valid_d    = valid_q;
        mem_en     = 1'b0;
        mem_addr   = '0;
        tmpl_we    = 1'b0;
        win_we     = 1'b0;
        buf_idx    = HEAD_W'(cnt_q - CNT_W'(1));

        // Circular read index: win[(head + j) mod TMPL_LEN]
        mac_j   = HEAD_W'(cnt_q);
        win_sum = (HEAD_W + 1)'(head_q) + (HEAD_W + 1)'(mac_j);
        if (win_sum >= SUM_WRAP) begin
            win_sum = win_sum - SUM_WRAP;
        end
        prod = tmpl_q[mac_j] * win_q[win_sum[HEAD_W-1:0]];

        // Magnitude needs one extra bit so the most negative sum stays representable.
        cand_m = {acc_q[ACC_W-1], acc_q};
        best_m = {best_val_q[ACC_W-1], best_val_q};
        if (mode_q) begin
            if (cand_m[ACC_W]) cand_m = -cand_m;
            if (best_m[ACC_W]) best_m = -best_m;
        end
        take = (pos_q == '0) || (cand_m > best_m);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_T;
                    mode_d  = mode;
                    valid_d = 1'b0;
                    pos_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_LOAD_T, S_LOAD_S: begin
                if (cnt_q != CNT_LOAD_LAST) begin
                    mem_en   = 1'b1;
                    mem_addr = ((state_q == S_LOAD_T) ? TMPL_BASE_A : SIG_BASE_A)
                               + ADDR_W'(cnt_q);
                end
                if (cnt_q != '0) begin
                    tmpl_we = (state_q == S_LOAD_T);
                    win_we  = (state_q == S_LOAD_S);
                end
                if (cnt_q == CNT_LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_LOAD_T) ? S_LOAD_S : S_MAC;
                    head_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MAC: begin
                acc_d = ((cnt_q == '0) ? '0 : acc_q) + ACC_W'(prod);
                if (cnt_q == CNT_MAC_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CMP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CMP: begin
                if (take) begin
                    best_val_d = acc_q;
                    best_idx_d = pos_q;
                end
                state_d = (pos_q == POS_LAST) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                mem_en   = 1'b1;
                mem_addr = SIG_BASE_A + ADDR_W'(pos_q) + TMPL_LEN_A;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                win_we  = 1'b1;
                buf_idx = head_q;
                head_d  = (head_q == HEAD_LAST) ? '0 : head_q + HEAD_W'(1);
                pos_d   = pos_q + IDX_W'(1);
                cnt_d   = '0;
                state_d = S_MAC;
            end
            S_DONE: begin
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registers use <= so every flop samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            head_q     <= '0;
            pos_q      <= '0;
            acc_q      <= '0;
            mode_q     <= 1'b0;
            best_val_q <= '0;
            best_idx_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            pos_q      <= pos_d;
            acc_q      <= acc_d;
            mode_q     <= mode_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            valid_q    <= valid_d;
        end
    end

    // NOTE: sample buffers are not reset; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (tmpl_we) tmpl_q[buf_idx] <= mem_rdata;
        if (win_we)  win_q[buf_idx]  <= mem_rdata;
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign result_valid = valid_q;
    assign best_val     = best_val_q;
    assign best_idx     = best_idx_q;

endmodule

// File: tb/tb_xcorr_search.sv
// Scoreboard bench for xcorr_search: three instances (4/8, default 64/1024, 4/4) with
// SRAM models; expected results are queued at start and popped on each done pulse.
`timescale 1ns/1ps
module tb_xcorr_search;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        longint val;
        longint idx;
    } exp_t;

    exp_t q_a[$], q_b[$], q_c[$];
    exp_t e_a, e_b, e_c;
    int   log_a[$], log_c[$];
    int   tv[4];
    int   sv[8];
    int   exp_addr[12];

    // Instance A: TMPL_LEN=4, SIG_LEN=8
    logic               start_a, mode_a, mem_en_a, busy_a, done_a, rv_a;
    logic [10:0]        addr_a;
    logic [7:0]         rdata_a;
    logic signed [17:0] bv_a;
    logic [2:0]         bi_a;
    logic [7:0]         mem_a [0:2047];

    xcorr_search #(.DATA_W(8), .TMPL_LEN(4), .SIG_LEN(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
        .mem_en(mem_en_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
        .busy(busy_a), .done(done_a), .result_valid(rv_a),
        .best_val(bv_a), .best_idx(bi_a));

    // Instance B: default parameters
    logic               start_b, mode_b, mem_en_b, busy_b, done_b, rv_b;
    logic [10:0]        addr_b;
    logic [7:0]         rdata_b;
    logic signed [21:0] bv_b;
    logic [9:0]         bi_b;
    logic [7:0]         mem_b [0:2047];

    xcorr_search u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
        .mem_en(mem_en_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
        .busy(busy_b), .done(done_b), .result_valid(rv_b),
        .best_val(bv_b), .best_idx(bi_b));

    // Instance C: TMPL_LEN = SIG_LEN = 4
    logic               start_c, mode_c, mem_en_c, busy_c, done_c, rv_c;
    logic [10:0]        addr_c;
    logic [7:0]         rdata_c;
    logic signed [17:0] bv_c;
    logic [0:0]         bi_c;
    logic [7:0]         mem_c [0:2047];

    xcorr_search #(.DATA_W(8), .TMPL_LEN(4), .SIG_LEN(4)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .mode(mode_c),
        .mem_en(mem_en_c), .mem_addr(addr_c), .mem_rdata(rdata_c),
        .busy(busy_c), .done(done_c), .result_valid(rv_c),
        .best_val(bv_c), .best_idx(bi_c));

    always @(posedge clk) if (mem_en_a) rdata_a <= mem_a[addr_a];
    always @(posedge clk) if (mem_en_b) rdata_b <= mem_b[addr_b];
    always @(posedge clk) if (mem_en_c) rdata_c <= mem_c[addr_c];

    always @(negedge clk) if (mem_en_a) log_a.push_back(int'(addr_a));
    always @(negedge clk) if (mem_en_c) log_c.push_back(int'(addr_c));

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitors: pop one expected result per done pulse.
    always @(negedge clk) begin
        if (done_a) begin
            check("a_done_expected", longint'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                e_a = q_a.pop_front();
                check("a_best_val", longint'(bv_a), e_a.val);
                check("a_best_idx", longint'(bi_a), e_a.idx);
            end
        end
    end

    always @(negedge clk) begin
        if (done_b) begin
            check("b_done_expected", longint'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                e_b = q_b.pop_front();
                check("b_best_val", longint'(bv_b), e_b.val);
                check("b_best_idx", longint'(bi_b), e_b.idx);
            end
        end
    end

    always @(negedge clk) begin
        if (done_c) begin
            check("c_done_expected", longint'(q_c.size() != 0), 1);
            if (q_c.size() != 0) begin
                e_c = q_c.pop_front();
                check("c_best_val", longint'(bv_c), e_c.val);
                check("c_best_idx", longint'(bi_c), e_c.idx);
            end
        end
    end

    function automatic logic done_of(input int w);
        case (w)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic rv_of(input int w);
        case (w)
            0:       return rv_a;
            1:       return rv_b;
            default: return rv_c;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    task automatic push_exp(input int w, input longint v, input longint i);
        exp_t e;
        e.val = v;
        e.idx = i;
        case (w)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    // Called at a negedge; start is seen by exactly one rising edge (E).
    // Returns at the negedge of the first cycle after E.
    task automatic start_pulse(input int w, input logic m, input string tag);
        case (w)
            0:       begin mode_a = m; start_a = 1'b1; end
            1:       begin mode_b = m; start_b = 1'b1; end
            default: begin mode_c = m; start_c = 1'b1; end
        endcase
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        check({tag, "_busy_after_start"}, longint'(busy_of(w)), 1);
        check({tag, "_valid_cleared"}, longint'(rv_of(w)), 0);
    endtask

    // Counts cycles after E until done; returns in the IDLE cycle after DONE.
    task automatic wait_done(input int w, input string tag, input int cyc0, input int exp_cyc);
        int cyc;
        cyc = cyc0;
        while (!done_of(w) && cyc < exp_cyc + 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_cycle"}, done_of(w) ? longint'(cyc) : -1, longint'(exp_cyc));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, longint'(done_of(w)), 0);
        check({tag, "_result_valid"}, longint'(rv_of(w)), 1);
        check({tag, "_busy_low"}, longint'(busy_of(w)), 0);
    endtask

    task automatic load_a();
        for (int i = 0; i < 4; i++) mem_a[i] = 8'(tv[i]);
        for (int i = 0; i < 8; i++) mem_a[64 + i] = 8'(sv[i]);
    endtask

    initial begin
        start_a = 1'b0; mode_a = 1'b0;
        start_b = 1'b0; mode_b = 1'b0;
        start_c = 1'b0; mode_c = 1'b0;
        rst_n   = 1'b0;
        for (int i = 0; i < 2048; i++) mem_b[i] = 8'h80;
        mem_c[0] = 8'd2; mem_c[1] = 8'hFD; mem_c[2] = 8'd0; mem_c[3] = 8'd1;
        for (int i = 64; i < 68; i++) mem_c[i] = 8'd1;
        exp_addr = '{0, 1, 2, 3, 64, 65, 66, 67, 68, 69, 70, 71};

        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy_a), 0);
        check("rst_done", longint'(done_a), 0);
        check("rst_valid", longint'(rv_a), 0);
        check("rst_mem_en", longint'(mem_en_a), 0);
        check("rst_best_val", longint'(bv_a), 0);
        check("rst_best_idx", longint'(bi_a), 0);
        check("rst_busy_b", longint'(busy_b), 0);
        check("rst_busy_c", longint'(busy_c), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: peak at position 2, timing and address sequence
        tv = '{1, 2, 3, 4};
        sv = '{0, 0, 1, 2, 3, 4, 0, 0};
        load_a();
        log_a.delete();
        push_exp(0, 30, 2);
        start_pulse(0, 1'b0, "t1");
        wait_done(0, "t1", 1, 44);
        check("t1_addr_count", longint'(log_a.size()), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < log_a.size()) check("t1_addr", longint'(log_a[i]), longint'(exp_addr[i]));
        end

        // 2: signed vs magnitude; second start lands in the IDLE cycle right after DONE
        tv = '{1, 1, 1, 1};
        sv = '{-128, -128, -128, -128, 1, 1, 1, 1};
        load_a();
        push_exp(0, 4, 4);
        start_pulse(0, 1'b0, "t2_m0");
        wait_done(0, "t2_m0", 1, 44);
        push_exp(0, -512, 0);
        start_pulse(0, 1'b1, "t2_m1");
        wait_done(0, "t2_m1", 1, 44);

        // 3: tie keeps the lower index
        tv = '{1, 0, 0, 0};
        sv = '{5, 0, 0, 0, 5, 0, 0, 0};
        load_a();
        push_exp(0, 5, 0);
        start_pulse(0, 1'b0, "t3");
        wait_done(0, "t3", 1, 44);

        // 5a: start pulsed during MAC of position 0 is ignored
        tv = '{1, 2, 3, 4};
        sv = '{0, 0, 1, 2, 3, 4, 0, 0};
        load_a();
        push_exp(0, 30, 2);
        start_pulse(0, 1'b0, "t5a");
        repeat (11) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, "t5a", 13, 44);

        // 5b: one-cycle reset during MAC of position 2 aborts the search
        start_pulse(0, 1'b0, "t5b");
        repeat (25) @(negedge clk);
        check("t5b_best_before_reset", longint'(bv_a), 20);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5b_busy", longint'(busy_a), 0);
        check("t5b_done", longint'(done_a), 0);
        check("t5b_valid", longint'(rv_a), 0);
        check("t5b_mem_en", longint'(mem_en_a), 0);
        check("t5b_best_val", longint'(bv_a), 0);
        check("t5b_best_idx", longint'(bi_a), 0);
        repeat (60) @(negedge clk);
        check("t5b_stays_idle", longint'(busy_a), 0);

        // 5c: restart after abort reproduces scenario 1
        push_exp(0, 30, 2);
        start_pulse(0, 1'b0, "t5c");
        wait_done(0, "t5c", 1, 44);

        // 6: single position, no FETCH access
        log_c.delete();
        push_exp(2, 0, 0);
        start_pulse(2, 1'b0, "t6");
        wait_done(2, "t6", 1, 16);
        check("t6_addr_count", longint'(log_c.size()), 8);
        if (log_c.size() != 0) check("t6_last_addr", longint'(log_c[log_c.size() - 1]), 67);

        // 4: default sizes, all samples -128
        push_exp(1, 1048576, 0);
        start_pulse(1, 1'b0, "t4");
        wait_done(1, "t4", 1, 64516);

        check("a_queue_drained", longint'(q_a.size()), 0);
        check("b_queue_drained", longint'(q_b.size()), 0);
        check("c_queue_drained", longint'(q_c.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
